// File: rtl/acc_readout.sv
// Accumulator drain: snapshots all lanes, clears them on the same edge, then streams one lane per beat.
// Optional ACC_READOUT_SAT_EN: beats flagged with overflow report all-ones instead of the wrapped value.
module acc_readout #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int NUM_LANES     = 4,
  parameter int IDX_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               drain_req,
  output logic                               drain_busy,
  input  logic [NUM_LANES*MAC_ACC_WIDTH-1:0] acc_in,
  input  logic [NUM_LANES-1:0]               acc_carry,
  output logic                               acc_clr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [MAC_ACC_WIDTH-1:0]           out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_ovf,
  output logic                               out_last
);

  // state | meaning
  // IDLE  | waiting for drain_req; sticky carry flags accumulate
  // SEND  | streaming snapshot lanes, one per accepted beat
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  state_t                                   state;
  logic [IDX_W-1:0]                         idx;
  logic [NUM_LANES-1:0]                     sticky_ovf;
  logic [NUM_LANES-1:0]                     shadow_ovf;
  logic [NUM_LANES-1:0][MAC_ACC_WIDTH-1:0]  shadow;
  logic [MAC_ACC_WIDTH-1:0]                 lane_data;
  logic                                     sending;
  logic                                     at_last;

  assign sending = (state == SEND);
  assign at_last = (idx == LAST_IDX);
  // Combinational so the accumulators reload on the same edge that takes the snapshot.
  assign acc_clr = drain_req & (state == IDLE) & ~rst;

`ifdef ACC_READOUT_SAT_EN
  assign lane_data = shadow_ovf[idx] ? {MAC_ACC_WIDTH{1'b1}} : shadow[idx];
`else
  assign lane_data = shadow[idx];
`endif

  assign out_valid  = sending;
  assign drain_busy = sending;
  assign out_data   = sending ? lane_data : '0;
  assign out_idx    = sending ? idx : '0;
  assign out_ovf    = sending & shadow_ovf[idx];
  assign out_last   = sending & at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      sticky_ovf <= '0;
      shadow_ovf <= '0;
      shadow     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (drain_req) begin
            shadow     <= acc_in;
            shadow_ovf <= sticky_ovf | acc_carry;
            sticky_ovf <= '0;
            idx        <= '0;
            state      <= SEND;
          end else begin
            sticky_ovf <= sticky_ovf | acc_carry;
          end
        end
        SEND: begin
          sticky_ovf <= sticky_ovf | acc_carry;
          if (out_ready) begin
            if (at_last) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_readout.md
Name: acc_readout

Overview:
Drain-side counterpart to the MAC accumulator lanes. On a drain request it snapshots all NUM_LANES accumulator values and pulses their clear in the same cycle, so no sample is lost. It then streams the snapshot out one lane per beat over a valid/ready interface, tagged with a sticky per-lane carry/overflow flag. It sits between the accumulator array and the result writeback path.

Parameters:
MAC_MIN_WIDTH, 8, minimum MAC operand width; informational, keeps parameter lists uniform across the MAC blocks.
MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of one accumulator lane and of out_data.
NUM_LANES, 4, number of accumulator lanes drained; must be >= 1.
IDX_W, $clog2(NUM_LANES) (minimum 1), width of out_idx.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high. Clock is clk.
drain_req  input  1  request a snapshot and readout; level-sampled.
drain_busy  output  1  high while a readout is in progress.
acc_in  input  NUM_LANES*MAC_ACC_WIDTH  current accumulator outputs; lane i at bits [i*W +: W].
acc_carry  input  NUM_LANES  per-lane carry_out from the accumulators.
acc_clr  output  1  clear/reload-init strobe to the accumulators' reset input.
out_valid  output  1  beat valid.
out_ready  input  1  downstream ready.
out_data  output  MAC_ACC_WIDTH  lane value.
out_idx  output  IDX_W  lane index of the current beat.
out_ovf  output  1  sticky overflow flag of this lane.
out_last  output  1  marks the final beat (lane NUM_LANES-1).

Behaviour:
- FSM states: IDLE, SEND.
- Reset state: IDLE, idx=0, sticky_ovf=0, shadow regs=0.
- Output values in reset: out_valid=0, drain_busy=0, acc_clr=0, out_data=0, out_idx=0, out_ovf=0, out_last=0.
- acc_clr = drain_req & (state==IDLE) & ~rst. It is combinational, so the accumulators reload init on the same edge that captures the snapshot.
- IDLE, on the edge where acc_clr=1:
  - shadow[i] <= acc_in lane i.
  - shadow_ovf[i] <= sticky_ovf[i] | acc_carry[i].
  - sticky_ovf <= 0; idx <= 0; state <= SEND.
- IDLE otherwise: sticky_ovf[i] <= sticky_ovf[i] | acc_carry[i] every cycle.
- SEND:
  - out_valid=1, out_data=shadow[idx], out_ovf=shadow_ovf[idx], out_idx=idx, out_last=(idx==NUM_LANES-1), drain_busy=1.
  - sticky_ovf continues to accumulate acc_carry.
- Handshake:
  - A beat transfers on out_valid&out_ready; then idx <= idx+1.
  - If out_last is set, the transfer instead sets state <= IDLE and idx <= 0.
  - out_data, out_idx, out_ovf and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops before the transfer.
- Latency:
  - drain_req high in IDLE at edge k: first beat is valid in the cycle after k.
  - Minimum drain period is NUM_LANES+1 cycles.
- drain_req while in SEND (including the last-beat transfer cycle): ignored, with no acc_clr. If still high in the next IDLE cycle it is accepted then.
- out_valid=0 in IDLE; out_data, out_idx, out_ovf and out_last are driven to 0 in IDLE.
- NUM_LANES=1: a single beat with out_last=1, out_idx=0.
- Reset mid-SEND: the next cycle is IDLE with out_valid=0; the snapshot is discarded and no beats are replayed.
- Overflow semantics: carry is unsigned lane-local wrap; the flag is sticky from one snapshot to the next.

Optional Feature:
ACC_READOUT_SAT_EN:
- Defined: a beat with out_ovf=1 outputs out_data = all-ones (2^MAC_ACC_WIDTH-1) instead of the wrapped value; out_ovf is still reported.
- Undefined: out_data is always the raw wrapped snapshot value.

Test Plan:
1. Reset, then drive lanes {5,6,7,8} with acc_carry=0 and out_ready=1, and pulse drain_req for 1 cycle. Required: acc_clr=1 for exactly 1 cycle; beats 5,6,7,8 with out_idx 0..3; out_last only on 8; out_ovf=0; drain_busy low after the 4th beat.
2. Backpressure: hold out_ready=0 for 3 cycles on beat 1 (value 6). Required: out_data=6 and out_idx=1 stable, out_valid held at 1, no skipped or duplicated beats.
3. Pulse acc_carry[2]=1 for one cycle, 10 cycles before drain_req. Required:
   - Lane 2 beat has out_ovf=1.
   - Undefined macro: data is the raw value. With ACC_READOUT_SAT_EN: data=32'hFFFFFFFF.
   - A second drain with no carry reports out_ovf=0.
4. Hold drain_req=1 continuously with out_ready=1. Required: acc_clr pulses every 5 cycles (NUM_LANES+1); no acc_clr during SEND.
5. Assert rst during beat 2 of a drain. Required: out_valid=0 and drain_busy=0 the next cycle; acc_clr=0 while rst=1; a new drain after reset starts at out_idx=0 with the fresh snapshot.
6. NUM_LANES=1 instance, value 42. Required: a single beat with out_last=1 and out_idx=0; back in IDLE the cycle after the transfer.
